// File: rtl/fsk_rx_frame_ctrl_pkg.sv
// rtl/fsk_rx_frame_ctrl_pkg.sv - shared types and defaults for the FSK receive framer
package fsk_rx_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam int         SYNC_LEN_DEF  = 8;
  localparam logic [7:0] SYNC_WORD_DEF = 8'b1010_1101;
  localparam int         CW_LEN_DEF    = 7;
  localparam int         NWORDS_DEF    = 4;
  localparam int         TIMEOUT_DEF   = 255;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsk_rx_frame_ctrl_sync_detect.sv
// rtl/fsk_rx_frame_ctrl_sync_detect.sv - sliding sync-word detector on the strobed bit stream
module fsk_sync_detect
  import fsk_rx_pkg::*;
#(
  parameter int                  SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic clr,
  input  logic bit_in,
  output logic match
);

  // The oldest bit only ever takes part in the compare, so it is never stored.
  logic [SYNC_LEN-2:0] sreg;
  logic [SYNC_LEN-1:0] sreg_upd;

  assign sreg_upd = {sreg, bit_in};
  assign match    = shift_en && (sreg_upd == SYNC_WORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (clr) begin
      sreg <= '0;
    end else if (shift_en) begin
      sreg <= sreg_upd[SYNC_LEN-2:0];
    end
  end

endmodule

// File: rtl/fsk_rx_frame_ctrl.sv
// rtl/fsk_rx_frame_ctrl.sv - sync hunt, codeword framing and valid/ready holding register
module fsk_rx_frame_ctrl
  import fsk_rx_pkg::*;
#(
  parameter int                  SYNC_LEN  = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                  CW_LEN    = CW_LEN_DEF,
  parameter int                  NWORDS    = NWORDS_DEF,
  parameter int                  TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_strobe,
  output logic [CW_LEN-1:0] cw_data,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic              frame_active,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow
);

  localparam int BCW = cnt_w(CW_LEN);
  localparam int WCW = cnt_w(NWORDS);
  localparam int TCW = cnt_w(TIMEOUT);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CW_LEN - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NWORDS - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [TCW-1:0]    tmo_cnt;
  logic [CW_LEN-2:0] word_sr;
  logic [CW_LEN-1:0] word_full;

  logic in_collect, strobe_en, take_bit, word_end, last_word;
  logic hold_free, load, timeout_hit;
  logic sync_shift, sync_clr, sync_match;

  assign in_collect  = (state == COLLECT);
  assign strobe_en   = enable & bit_strobe;
  assign take_bit    = in_collect & strobe_en;
  assign word_full   = {word_sr, bit_in};
  assign word_end    = take_bit & (bit_cnt == BIT_LAST);
  assign last_word   = word_end & (word_cnt == WORD_LAST);
  assign hold_free   = ~cw_valid | cw_ready;
  assign load        = word_end & hold_free;
  // tmo_cnt holds idle cycles already elapsed; this cycle would be the TIMEOUT-th.
  assign timeout_hit = in_collect & enable & ~bit_strobe & (tmo_cnt == TMO_LAST);
  assign sync_shift  = ~in_collect & strobe_en;
  assign sync_clr    = ~enable | last_word;

  assign frame_active = in_collect;

  fsk_sync_detect #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .shift_en (sync_shift),
    .clr      (sync_clr),
    .bit_in   (bit_in),
    .match    (sync_match)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = HUNT;
    end else begin
      case (state)
        HUNT:    if (sync_match) state_next = COLLECT;
        COLLECT: if (last_word || timeout_hit) state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
      word_sr  <= '0;
    end else begin
      if (!in_collect || !enable || timeout_hit || word_end) bit_cnt <= '0;
      else if (take_bit)                                    bit_cnt <= bit_cnt + 1'b1;

      if (!in_collect || !enable || timeout_hit || last_word) word_cnt <= '0;
      else if (word_end)                                     word_cnt <= word_cnt + 1'b1;

      if (!in_collect || !enable || bit_strobe || timeout_hit) tmo_cnt <= '0;
      else                                                     tmo_cnt <= tmo_cnt + 1'b1;

      if (take_bit) word_sr <= word_full[CW_LEN-2:0];
    end
  end

  // Holding register keeps handshaking regardless of enable or FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cw_data    <= '0;
      cw_valid   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load) begin
        cw_data  <= word_full;
        cw_valid <= 1'b1;
      end else if (cw_valid && cw_ready) begin
        cw_valid <= 1'b0;
      end
      frame_done <= last_word;
      frame_err  <= timeout_hit;
      overflow   <= word_end & ~hold_free;
    end
  end

endmodule

// File: tb/tb_fsk_rx_frame_ctrl.sv
// tb/tb_fsk_rx_frame_ctrl.sv - directed and randomized self-checking bench for fsk_rx_frame_ctrl
module tb_fsk_rx_frame_ctrl;

  localparam logic [7:0] SYNC = 8'hAD;
  localparam int CWL = 7;
  localparam int NW  = 4;
  localparam int TMO = 255;

  logic clk = 0, reset = 0, enable = 0, bit_in = 0, bit_strobe = 0, cw_ready = 0;
  logic [CWL-1:0] cw_data;
  logic cw_valid, frame_active, frame_done, frame_err, overflow;

  fsk_rx_frame_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_in(bit_in), .bit_strobe(bit_strobe),
    .cw_data(cw_data), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .frame_active(frame_active), .frame_done(frame_done), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int n_done = 0, n_ferr = 0, n_ovf = 0;
  bit check_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is "sync seen, then NW groups of CWL strobed bits".
  bit       m_hunt = 1;
  int       m_sync = 0;
  bit       m_bits[$];
  int       m_words = 0, m_idle = 0;
  logic     m_valid = 0;
  logic [CWL-1:0] m_data = '0;
  logic     m_done = 0, m_ferr = 0, m_ovf = 0;
  logic     pend_valid = 0;
  logic [CWL-1:0] pend_data = '0;
  logic [CWL-1:0] acc_q[$];

  task automatic model_reset();
    m_hunt = 1; m_sync = 0; m_bits.delete(); m_words = 0; m_idle = 0;
    m_valid = 0; m_data = '0; m_done = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit accept, new_load;
    logic [CWL-1:0] w;
    accept = m_valid && cw_ready;
    new_load = 0; w = '0;
    m_done = 0; m_ferr = 0; m_ovf = 0;
    if (!enable) begin
      m_hunt = 1; m_sync = 0; m_bits.delete(); m_words = 0; m_idle = 0;
    end else if (m_hunt) begin
      if (bit_strobe) begin
        m_sync = ((m_sync << 1) | int'(bit_in)) & 8'hFF;
        if (m_sync == int'(SYNC)) begin
          m_hunt = 0; m_bits.delete(); m_words = 0; m_idle = 0;
        end
      end
    end else if (bit_strobe) begin
      m_idle = 0;
      m_bits.push_back(bit_in);
      if (m_bits.size() == CWL) begin
        foreach (m_bits[i]) w = {w[CWL-2:0], m_bits[i]};
        if (!m_valid || cw_ready) new_load = 1;
        else m_ovf = 1;
        m_bits.delete();
        m_words++;
        if (m_words == NW) begin
          m_done = 1; m_hunt = 1; m_sync = 0;
        end
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_ferr = 1; m_hunt = 1; m_bits.delete(); m_idle = 0;
      end
    end
    if (new_load) begin
      m_valid = 1; m_data = w;
    end else if (accept) begin
      m_valid = 0;
    end
  endtask

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      model_reset();
    end else begin
      if (pend_valid && cw_ready) acc_q.push_back(pend_data);
      model_step();
    end
    #1;
    if (check_en) begin
      n_chk++;
      if ({cw_valid, cw_data, frame_active, frame_done, frame_err, overflow} !==
          {m_valid, m_data, !m_hunt, m_done, m_ferr, m_ovf}) begin
        n_err++;
        $display("FAIL cycle_compare: got v=%b d=%h act=%b done=%b err=%b ovf=%b expected v=%b d=%h act=%b done=%b err=%b ovf=%b at %0t",
                 cw_valid, cw_data, frame_active, frame_done, frame_err, overflow,
                 m_valid, m_data, !m_hunt, m_done, m_ferr, m_ovf, $time);
      end
    end
    pend_valid = cw_valid;
    pend_data  = cw_data;
    if (frame_done) n_done++;
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
  end

  task automatic idle(input int n);
    bit_strobe = 0;
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic send_bit(input logic b);
    bit_strobe = 1; bit_in = b;
    @(posedge clk); #2;
    bit_strobe = 0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(v[i]);
      if (i != 0) idle(1);
    end
  endtask

  logic [CWL-1:0] words [4] = '{7'h55, 7'h2A, 7'h7F, 7'h00};
  logic [31:0] hunt_stream = 32'b1010_1010_1101;
  bit bq[$];
  int gap_left = 0;
  int k, d0, e0, o0;

  initial begin
    // 1: reset and first sync
    repeat (3) @(posedge clk);
    #2; check_en = 1; enable = 1;
    reset = 1;
    chk("reset_outs", {cw_valid, cw_data, frame_active, frame_done, frame_err, overflow}, 0);
    idle(1);
    send_bits(SYNC, 8);
    chk("sync_active", frame_active, 1);

    // 2: full frame with ready held high
    acc_q.delete(); cw_ready = 1; d0 = n_done;
    for (int w = 0; w < NW; w++) begin
      idle(1);
      send_bits(words[w], CWL);
      chk("cw_valid_lat", cw_valid, 1);
      chk("cw_data_lat", cw_data, words[w]);
    end
    chk("model_pin_data", m_data, 7'h00);
    chk("frame_done", frame_done, 1);
    chk("active_after_frame", frame_active, 0);
    idle(2);
    chk("done_count", n_done - d0, 1);
    chk("accept_count", acc_q.size(), 4);
    for (int w = 0; w < 4; w++)
      if (w < acc_q.size()) chk("accept_word", acc_q[w], words[w]);

    // 3: backpressure for the whole frame
    cw_ready = 0; o0 = n_ovf;
    idle(1);
    send_bits(SYNC, 8);
    for (int w = 0; w < NW; w++) begin
      idle(1);
      send_bits(words[w], CWL);
      chk("bp_overflow", overflow, (w == 0) ? 0 : 1);
      chk("bp_done", frame_done, (w == NW - 1) ? 1 : 0);
      chk("bp_hold_data", cw_data, 7'h55);
    end
    idle(3);
    chk("bp_ovf_count", n_ovf - o0, 3);
    chk("bp_still_valid", cw_valid, 1);
    chk("model_pin_hold", m_data, 7'h55);
    cw_ready = 1;
    idle(1);
    chk("bp_released", cw_valid, 0);

    // 4: inter-bit timeout, then a strobe landing on the last allowed cycle
    idle(1);
    send_bits(SYNC, 8); idle(1);
    send_bits(3'b101, 3);
    k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (!frame_err && k < 400);
    chk("timeout_cycles", k, TMO);
    chk("timeout_hunt", frame_active, 0);
    chk("timeout_valid", cw_valid, 0);
    e0 = n_ferr;
    idle(1);
    send_bits(SYNC, 8); idle(1);
    send_bits(3'b011, 3);
    idle(TMO - 1);
    send_bit(1'b1);
    chk("late_strobe_active", frame_active, 1);
    chk("late_strobe_noerr", n_ferr - e0, 0);
    enable = 0; idle(1); enable = 1;

    // 5: sync hunt with overlapping prefix, then a near-miss pattern
    for (int i = 11; i >= 0; i--) begin
      send_bit(hunt_stream[i]);
      chk("hunt_match", frame_active, (i == 0) ? 1 : 0);
      idle(1);
    end
    enable = 0; idle(1); enable = 1;
    send_bits(8'hAC, 8);
    chk("false_sync", frame_active, 0);

    // 6: enable abort mid-word, then async reset with a held word
    enable = 0; idle(1); enable = 1; e0 = n_ferr;
    send_bits(SYNC, 8); idle(1);
    send_bits(3'b110, 3);
    enable = 0; idle(1);
    chk("abort_hunt", frame_active, 0);
    enable = 1; idle(3);
    chk("abort_noerr", n_ferr - e0, 0);
    cw_ready = 0;
    send_bits(SYNC, 8); idle(1);
    send_bits(7'h33, 7);
    chk("pre_reset_valid", cw_valid, 1);
    #1 reset = 0;
    #1 chk("async_reset_valid", cw_valid, 0);
    @(posedge clk); #2 reset = 1;
    idle(1);

    // Randomized traffic, biased towards sync words so frames actually form
    for (int c = 0; c < 30000; c++) begin
      enable   = ($urandom_range(0, 299) != 0);
      cw_ready = $urandom_range(0, 1);
      if (gap_left > 0) begin
        bit_strobe = 0; gap_left--;
      end else begin
        if (bq.size() == 0) begin
          if ($urandom_range(0, 2) == 0)
            for (int i = 7; i >= 0; i--) bq.push_back(SYNC[i]);
          repeat ($urandom_range(1, 30)) bq.push_back($urandom_range(0, 1));
        end
        bit_strobe = 1;
        bit_in = bq.pop_front();
        gap_left = ($urandom_range(0, 79) == 0) ? $urandom_range(TMO - 3, TMO + 3)
                                                : $urandom_range(0, 2);
      end
      @(posedge clk); #2;
    end
    bit_strobe = 0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
